// File: rtl/ct_ebiu_lowpower_ctrl.sv
// ct_ebiu_lowpower_ctrl: AXI-style csysreq/csysack/cactive low-power handshake for a multi-channel EBIU,
// with drain-before-accept, timeout deny and an idle-driven cactive hint.
module ct_ebiu_lowpower_ctrl #(
   parameter int CH_NUM       = 3,
   parameter int IDLE_THRESH  = 8,
   parameter int DENY_TIMEOUT = 64,
   parameter int CNT_W        = 7
) (
   input  logic              forever_cpuclk,
   input  logic              cpurst,
   input  logic              clk_en,
   input  logic [CH_NUM-1:0] ebiu_chan_no_op,
   input  logic              ebiu_req_pending,
   input  logic              pad_ebiu_csysreq,
   output logic              ebiu_pad_csysack,
   output logic              ebiu_pad_cactive,
   output logic              ebiu_xx_no_op,
   output logic              ebiu_xx_lp_block,
   output logic              ebiu_lp_deny
);
   typedef enum logic [1:0] {RUN, DRAIN, LP, DENIED} state_t;

   localparam logic [CNT_W-1:0] ITH = CNT_W'(IDLE_THRESH);
   localparam logic [CNT_W-1:0] DTO = CNT_W'(DENY_TIMEOUT);

   state_t           state_q;
   logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d, deny_cnt_q, deny_cnt_d;
   logic             csysack_q, cactive_q, lp_block_q, lp_deny_q;
   logic             idle, idle_hit, deny_hit;

   assign ebiu_xx_no_op    = &ebiu_chan_no_op;
   assign idle             = ebiu_xx_no_op & ~ebiu_req_pending;
   assign ebiu_pad_csysack = csysack_q;
   assign ebiu_pad_cactive = cactive_q;
   assign ebiu_xx_lp_block = lp_block_q;
   assign ebiu_lp_deny     = lp_deny_q;

   always_comb begin
      idle_cnt_d = !idle ? '0 : (idle_cnt_q == ITH) ? idle_cnt_q : idle_cnt_q + CNT_W'(1);
      deny_cnt_d = deny_cnt_q + CNT_W'(1);
      idle_hit   = (IDLE_THRESH > 0) && (idle_cnt_d == ITH);
      deny_hit   = deny_cnt_d == DTO;
   end

   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         state_q    <= RUN;
         idle_cnt_q <= '0;
         deny_cnt_q <= '0;
         csysack_q  <= 1'b1;
         cactive_q  <= 1'b1;
         lp_block_q <= 1'b0;
         lp_deny_q  <= 1'b0;
      end else if (clk_en) begin
         lp_deny_q <= 1'b0;
         case (state_q)
            RUN: begin
               idle_cnt_q <= idle_cnt_d;
               cactive_q  <= ~idle_hit;
               // a pending low-power request keeps the clock alive while draining
               if (!pad_ebiu_csysreq) begin
                  state_q    <= DRAIN;
                  lp_block_q <= 1'b1;
                  deny_cnt_q <= '0;
                  cactive_q  <= 1'b1;
               end
            end
            DRAIN: begin
               if (pad_ebiu_csysreq) begin
                  state_q    <= RUN;
                  lp_block_q <= 1'b0;
               end else if (ebiu_xx_no_op) begin
                  state_q   <= LP;
                  csysack_q <= 1'b0;
                  cactive_q <= 1'b0;
               end else begin
                  deny_cnt_q <= deny_cnt_d;
                  if (deny_hit) begin
                     state_q    <= DENIED;
                     csysack_q  <= 1'b0;
                     cactive_q  <= 1'b1;
                     lp_block_q <= 1'b0;
                     lp_deny_q  <= 1'b1;
                  end
               end
            end
            LP: begin
               cactive_q <= ebiu_req_pending;
               if (pad_ebiu_csysreq) begin
                  state_q    <= RUN;
                  csysack_q  <= 1'b1;
                  cactive_q  <= 1'b1;
                  lp_block_q <= 1'b0;
                  idle_cnt_q <= '0;
               end
            end
            DENIED: begin
               if (pad_ebiu_csysreq) begin
                  state_q    <= RUN;
                  csysack_q  <= 1'b1;
                  idle_cnt_q <= '0;
               end
            end
            default: state_q <= RUN;
         endcase
      end
   end
endmodule

// File: tb/tb_ct_ebiu_lowpower_ctrl.sv
// tb_ct_ebiu_lowpower_ctrl: directed self-checking bench for the EBIU low-power handshake controller.
module tb_ct_ebiu_lowpower_ctrl;
   logic       clk = 1'b0, rst, clk_en, req_pending, csysreq;
   logic [2:0] no_op;
   logic       ack, cactive, xx_no_op, lp_block, lp_deny;
   int         errors = 0, checks = 0;

   ct_ebiu_lowpower_ctrl #(.CH_NUM(3), .IDLE_THRESH(8), .DENY_TIMEOUT(64), .CNT_W(7)) dut (
      .forever_cpuclk(clk), .cpurst(rst), .clk_en(clk_en),
      .ebiu_chan_no_op(no_op), .ebiu_req_pending(req_pending), .pad_ebiu_csysreq(csysreq),
      .ebiu_pad_csysack(ack), .ebiu_pad_cactive(cactive), .ebiu_xx_no_op(xx_no_op),
      .ebiu_xx_lp_block(lp_block), .ebiu_lp_deny(lp_deny));

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; clk_en = 1'b1; req_pending = 1'b0; csysreq = 1'b1; no_op = 3'b111;
      step(2);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rst_ack got=%b exp=1", ack); end
      checks++; if (cactive !== 1'b1) begin errors++; $display("FAIL rst_cactive got=%b exp=1", cactive); end
      checks++; if (lp_block !== 1'b0) begin errors++; $display("FAIL rst_block got=%b exp=0", lp_block); end
      checks++; if (lp_deny !== 1'b0) begin errors++; $display("FAIL rst_deny got=%b exp=0", lp_deny); end
      rst = 1'b0;
   endtask

   task automatic test_idle_cactive;
      step(7);
      checks++; if (cactive !== 1'b1) begin errors++; $display("FAIL idle7_cactive got=%b exp=1", cactive); end
      step(1);
      checks++; if (cactive !== 1'b0) begin errors++; $display("FAIL idle8_cactive got=%b exp=0", cactive); end
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL idle_ack got=%b exp=1", ack); end
      no_op = 3'b110; #1;
      checks++; if (xx_no_op !== 1'b0) begin errors++; $display("FAIL xx_no_op_busy got=%b exp=0", xx_no_op); end
      step(1);
      checks++; if (cactive !== 1'b1) begin errors++; $display("FAIL busy_cactive got=%b exp=1", cactive); end
      no_op = 3'b111; req_pending = 1'b1;
      step(8);
      checks++; if (cactive !== 1'b1) begin errors++; $display("FAIL pend_cactive got=%b exp=1", cactive); end
      req_pending = 1'b0;
      step(8);
      checks++; if (cactive !== 1'b0) begin errors++; $display("FAIL reidle_cactive got=%b exp=0", cactive); end
   endtask

   task automatic test_accept;
      csysreq = 1'b0;
      step(1);
      checks++; if ({lp_block, ack, cactive} !== 3'b111) begin errors++; $display("FAIL acc_drain got=%b exp=111", {lp_block, ack, cactive}); end
      step(1);
      checks++; if ({lp_block, ack, cactive} !== 3'b100) begin errors++; $display("FAIL acc_lp got=%b exp=100", {lp_block, ack, cactive}); end
      csysreq = 1'b1;
      step(1);
      checks++; if ({lp_block, ack, cactive} !== 3'b011) begin errors++; $display("FAIL acc_exit got=%b exp=011", {lp_block, ack, cactive}); end
      step(7);
      checks++; if (cactive !== 1'b1) begin errors++; $display("FAIL exit_idle7 got=%b exp=1", cactive); end
      step(1);
      checks++; if (cactive !== 1'b0) begin errors++; $display("FAIL exit_idle8 got=%b exp=0", cactive); end
   endtask

   task automatic test_wake_and_reset;
      csysreq = 1'b0;
      step(2);
      req_pending = 1'b1;
      step(1);
      checks++; if ({ack, cactive} !== 2'b01) begin errors++; $display("FAIL wake_hint got=%b exp=01", {ack, cactive}); end
      req_pending = 1'b0;
      step(1);
      checks++; if ({ack, cactive} !== 2'b00) begin errors++; $display("FAIL wake_drop got=%b exp=00", {ack, cactive}); end
      rst = 1'b1; #1;
      checks++; if ({ack, cactive, lp_block} !== 3'b110) begin errors++; $display("FAIL async_rst got=%b exp=110", {ack, cactive, lp_block}); end
      csysreq = 1'b1;
      step(1);
      rst = 1'b0;
   endtask

   task automatic test_deny;
      no_op = 3'b011;
      step(1);
      csysreq = 1'b0;
      step(1);
      step(63);
      checks++; if ({lp_deny, lp_block, ack} !== 3'b011) begin errors++; $display("FAIL deny_early got=%b exp=011", {lp_deny, lp_block, ack}); end
      step(1);
      checks++; if ({lp_deny, ack, cactive, lp_block} !== 4'b1010) begin errors++; $display("FAIL deny_pulse got=%b exp=1010", {lp_deny, ack, cactive, lp_block}); end
      step(1);
      checks++; if ({lp_deny, ack} !== 2'b00) begin errors++; $display("FAIL deny_clear got=%b exp=00", {lp_deny, ack}); end
      csysreq = 1'b1;
      step(1);
      checks++; if ({ack, lp_block, cactive} !== 3'b101) begin errors++; $display("FAIL deny_exit got=%b exp=101", {ack, lp_block, cactive}); end
   endtask

   task automatic test_abort;
      no_op = 3'b011; csysreq = 1'b0;
      step(1);
      no_op = 3'b111; csysreq = 1'b1;
      step(1);
      checks++; if ({ack, lp_block} !== 2'b10) begin errors++; $display("FAIL abort got=%b exp=10", {ack, lp_block}); end
      step(1);
      checks++; if ({ack, lp_block} !== 2'b10) begin errors++; $display("FAIL abort_run got=%b exp=10", {ack, lp_block}); end
   endtask

   task automatic test_clk_en_hold;
      no_op = 3'b011; csysreq = 1'b0;
      step(1);
      step(10);
      clk_en = 1'b0; no_op = 3'b111;
      step(5);
      checks++; if ({ack, lp_block, lp_deny} !== 3'b110) begin errors++; $display("FAIL hold_state got=%b exp=110", {ack, lp_block, lp_deny}); end
      no_op = 3'b011; clk_en = 1'b1;
      step(53);
      checks++; if (lp_deny !== 1'b0) begin errors++; $display("FAIL hold_cnt_early got=%b exp=0", lp_deny); end
      step(1);
      checks++; if (lp_deny !== 1'b1) begin errors++; $display("FAIL hold_cnt_deny got=%b exp=1", lp_deny); end
      clk_en = 1'b0;
      step(3);
      checks++; if (lp_deny !== 1'b1) begin errors++; $display("FAIL hold_deny_stays got=%b exp=1", lp_deny); end
      clk_en = 1'b1; csysreq = 1'b1;
      step(1);
      checks++; if ({ack, lp_deny} !== 2'b10) begin errors++; $display("FAIL hold_exit got=%b exp=10", {ack, lp_deny}); end
   endtask

   task automatic test_back_to_back;
      no_op = 3'b111; csysreq = 1'b0;
      step(2);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL b2b_lp1 got=%b exp=0", ack); end
      csysreq = 1'b1;
      step(1);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL b2b_run got=%b exp=1", ack); end
      csysreq = 1'b0;
      step(2);
      checks++; if ({ack, lp_block} !== 2'b01) begin errors++; $display("FAIL b2b_lp2 got=%b exp=01", {ack, lp_block}); end
      csysreq = 1'b1;
      step(1);
   endtask

   initial begin
      test_reset();
      test_idle_cactive();
      test_accept();
      test_wake_and_reset();
      test_deny();
      test_abort();
      test_clk_en_hold();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
